// File: rtl/nn_result_uart_tx.sv
// nn_result_uart_tx: UART 8N1 transmitter for the per-image classification result.
// Frame: A5, {pred,target}, yes[15:8], yes[7:0], no[15:8], no[7:0] (+ XOR checksum).
// Optional feature macro: NN_RESULT_TX_CHECKSUM_EN (adds checksum byte B6).
module nn_result_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_BITS     = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                send,
    input  logic [3:0]          pred_label,
    input  logic [3:0]          target_label,
    input  logic [CNT_BITS-1:0] yes,
    input  logic [CNT_BITS-1:0] no,
    output logic                tx_data,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

`ifdef NN_RESULT_TX_CHECKSUM_EN
    localparam int NBYTES = 7;
`else
    localparam int NBYTES = 6;
`endif
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  state;
    logic [BAUD_W-1:0]       baud_cnt;
    logic [2:0]              bit_idx;
    logic [2:0]              byte_idx;
    logic [NBYTES-1:0][7:0]  frame;
    logic [NBYTES-1:0][7:0]  snap;
    logic [15:0]             yes16;
    logic [15:0]             no16;
    logic [7:0]              cur_byte;
    logic                    line_bit;
    logic                    baud_end;
    logic                    last_byte;
    logic                    fin;

    assign yes16     = 16'(yes);
    assign no16      = 16'(no);
    assign cur_byte  = frame[byte_idx];
    assign baud_end  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_byte = (byte_idx == 3'(NBYTES - 1));

    // Snapshot of the frame contents built from the live inputs, loaded on accept
    always_comb begin
        snap    = '0;
        snap[0] = 8'hA5;
        snap[1] = {pred_label, target_label};
        snap[2] = yes16[15:8];
        snap[3] = yes16[7:0];
        snap[4] = no16[15:8];
        snap[5] = no16[7:0];
`ifdef NN_RESULT_TX_CHECKSUM_EN
        snap[6] = 8'hA5 ^ {pred_label, target_label} ^ yes16[15:8] ^ yes16[7:0]
                ^ no16[15:8] ^ no16[7:0];
`endif
    end

    // Line level implied by the current state; registered into tx_data next edge
    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = cur_byte[bit_idx];
            default: line_bit = 1'b1;
        endcase
    end

    // Frame FSM with baud/bit/byte counters; outputs lag the state by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            frame    <= '0;
            tx_data  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            fin      <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            tx_data <= line_bit;
            busy    <= (state != IDLE);
            done    <= fin;
            fin     <= 1'b0;
            if (send && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (send) begin
                        frame    <= snap;
                        byte_idx <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (last_byte) begin
                            state <= IDLE;
                            fin   <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
